// File: rtl/lottery_pkg.sv
// Shared definitions for the lottery draw block: state encoding, default
// parameters and internal register widths.
package lottery_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_NUM_PICKS = 6;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MIN_VAL   = 1;
   localparam int DEF_MAX_VAL   = 49;
   localparam int DEF_TIMEOUT   = 64;

   localparam int COUNT_W = 4;
   localparam int STALL_W = 8;

endpackage

// File: rtl/lottery_if.sv
// Handshake and result bundle between a draw requester and lottery_draw.
interface lottery_if
   import lottery_pkg::*;
#(
   parameter int NUM_PICKS = DEF_NUM_PICKS,
   parameter int WIDTH     = DEF_WIDTH
);

   logic                       start;
   logic [WIDTH-1:0]           rand_in;
   logic [NUM_PICKS*WIDTH-1:0] nums;
   logic [COUNT_W-1:0]         count;
   logic                       busy;
   logic                       done;
   logic                       err;

   modport master (
      output start, rand_in,
      input  nums, count, busy, done, err
   );

   modport slave (
      input  start, rand_in,
      output nums, count, busy, done, err
   );

endinterface

// File: rtl/lottery_dup_check.sv
// Combinational duplicate detector: flags a candidate that equals any of the
// first 'count' stored slots.
module lottery_dup_check
   import lottery_pkg::*;
#(
   parameter int NUM_PICKS = DEF_NUM_PICKS,
   parameter int WIDTH     = DEF_WIDTH
) (
   input  logic [NUM_PICKS*WIDTH-1:0] slots,
   input  logic [COUNT_W-1:0]         count,
   input  logic [WIDTH-1:0]           candidate,
   output logic                       hit
);

   // Unfilled slots are masked out so a cleared 0 never counts as a match.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NUM_PICKS; i++) begin
         if ((COUNT_W'(i) < count) && (slots[i*WIDTH +: WIDTH] == candidate)) begin
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lottery_draw.sv
// Collects NUM_PICKS unique in-range values from a free-running random source,
// aborting with err when the source stalls for TIMEOUT consecutive cycles.
module lottery_draw
   import lottery_pkg::*;
#(
   parameter int NUM_PICKS = DEF_NUM_PICKS,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MIN_VAL   = DEF_MIN_VAL,
   parameter int MAX_VAL   = DEF_MAX_VAL,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic     clk,
   input  logic     rst,
   lottery_if.slave bus
);

   localparam logic [WIDTH-1:0]   MIN_V       = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0]   MAX_V       = WIDTH'(MAX_VAL);
   localparam logic [COUNT_W-1:0] LAST_CNT    = COUNT_W'(NUM_PICKS - 1);
   localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT - 1);

   state_t                     state;
   state_t                     state_nxt;
   logic [NUM_PICKS*WIDTH-1:0] nums_q;
   logic [COUNT_W-1:0]         cnt;
   logic [STALL_W-1:0]         stall;
   logic                       busy_q;
   logic                       done_q;
   logic                       err_q;

   logic start_ok;
   logic in_range;
   logic hit;
   logic accept;
   logic reject;
   logic last_pick;
   logic timeout;

   lottery_dup_check #(
      .NUM_PICKS (NUM_PICKS),
      .WIDTH     (WIDTH)
   ) u_dup_check (
      .slots     (nums_q),
      .count     (cnt),
      .candidate (bus.rand_in),
      .hit       (hit)
   );

   assign start_ok  = bus.start && (state != ST_DRAW);
   assign in_range  = (bus.rand_in >= MIN_V) && (bus.rand_in <= MAX_V);
   assign accept    = (state == ST_DRAW) && in_range && !hit;
   assign reject    = (state == ST_DRAW) && !accept;
   assign last_pick = accept && (cnt == LAST_CNT);
   assign timeout   = reject && (stall == STALL_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_nxt = ST_DRAW;
            end
         end
         ST_DRAW: begin
            if (last_pick) begin
               state_nxt = ST_DONE;
            end else if (timeout) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A timeout leaves the partial result visible alongside err.
   always_ff @(posedge clk) begin
      if (rst) begin
         nums_q <= '0;
         cnt    <= '0;
         stall  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= (state_nxt == ST_DRAW);
         done_q <= last_pick;
         if (start_ok) begin
            nums_q <= '0;
            cnt    <= '0;
            stall  <= '0;
            err_q  <= 1'b0;
         end else if (accept) begin
            for (int i = 0; i < NUM_PICKS; i++) begin
               if (cnt == COUNT_W'(i)) begin
                  nums_q[i*WIDTH +: WIDTH] <= bus.rand_in;
               end
            end
            cnt   <= cnt + COUNT_W'(1);
            stall <= '0;
         end else if (reject) begin
            if (stall != '1) begin
               stall <= stall + STALL_W'(1);
            end
            if (timeout) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.nums  = nums_q;
   assign bus.count = cnt;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_lottery_draw.sv
// Bench for lottery_draw: a queue-based model of the draw rules checked every
// cycle, plus directed sequences with literal expected results.
module tb_lottery_draw;
   import lottery_pkg::*;

   localparam int NP = 6;
   localparam int W  = 8;

   localparam logic [63:0] NUMS_A = 64'h0000_1D12_1914_2C21;
   localparam logic [63:0] NUMS_B = 64'h0000_0403_0230_3101;

   logic clk = 1'b0;
   logic rst;

   lottery_if #(.NUM_PICKS(NP), .WIDTH(W)) bus ();

   lottery_draw #(
      .NUM_PICKS (NP),
      .WIDTH     (W),
      .MIN_VAL   (1),
      .MAX_VAL   (49),
      .TIMEOUT   (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: a list of picks so far plus a coarse activity flag.
   int picks[$];
   bit drawing  = 1'b0;
   int misses   = 0;
   bit m_done   = 1'b0;
   bit m_err    = 1'b0;

   function automatic bit alreadyPicked(int v);
      foreach (picks[i]) begin
         if (picks[i] == v) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [63:0] expectedNums();
      logic [63:0] r;
      r = '0;
      foreach (picks[i]) begin
         r[i*8 +: 8] = 8'(picks[i]);
      end
      return r;
   endfunction

   function automatic void modelStep(logic r, logic s, logic [7:0] v);
      int val;
      val = int'(v);
      if (r) begin
         picks.delete();
         drawing = 1'b0;
         misses  = 0;
         m_done  = 1'b0;
         m_err   = 1'b0;
      end else begin
         m_done = 1'b0;
         if (!drawing && s) begin
            picks.delete();
            misses  = 0;
            m_err   = 1'b0;
            drawing = 1'b1;
         end else if (drawing) begin
            if (val >= 1 && val <= 49 && !alreadyPicked(val)) begin
               picks.push_back(val);
               misses = 0;
               if (picks.size() == NP) begin
                  drawing = 1'b0;
                  m_done  = 1'b1;
               end
            end else begin
               misses++;
               if (misses >= 64) begin
                  drawing = 1'b0;
                  m_err   = 1'b1;
               end
            end
         end
      end
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic [7:0] v);
      rst         = r;
      bus.start   = s;
      bus.rand_in = v;
      @(negedge clk);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         modelStep(rst, bus.start, bus.rand_in);
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         checkOutput("model_nums",  64'(bus.nums),  expectedNums());
         checkOutput("model_count", 64'(bus.count), 64'(picks.size()));
         checkOutput("model_busy",  64'(bus.busy),  64'(drawing));
         checkOutput("model_done",  64'(bus.done),  64'(m_done));
         checkOutput("model_err",   64'(bus.err),   64'(m_err));
      end
   end

   initial begin
      int pulses;
      int seen_at;
      int src[16];
      int rej[10];
      int bnd[9];
      src = '{33, 44, 20, 25, 25, 18, 29, 18, 36, 1, 31, 13, 22, 5, 5, 5};
      rej = '{33, 33, 0, 50, 44, 200, 20, 25, 18, 29};
      bnd = '{1, 49, 0, 50, 255, 48, 2, 3, 4};

      // Reset then idle
      applyStimulus(1'b1, 1'b0, 8'd0);
      applyStimulus(1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'd33);
      checkOutput("idle_nums",  64'(bus.nums),  64'd0);
      checkOutput("idle_count", 64'(bus.count), 64'd0);
      checkOutput("idle_busy",  64'(bus.busy),  64'd0);
      checkOutput("idle_done",  64'(bus.done),  64'd0);
      checkOutput("idle_err",   64'(bus.err),   64'd0);

      // Basic draw
      applyStimulus(1'b0, 1'b1, 8'd7);
      checkOutput("basic_busy_start", 64'(bus.busy), 64'd1);
      checkOutput("basic_count_start", 64'(bus.count), 64'd0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 8'(src[(i < 4) ? i : 5]));
         checkOutput("basic_count_step", 64'(bus.count), 64'(i + 1));
         checkOutput("basic_done_early", 64'(bus.done), 64'd0);
      end
      applyStimulus(1'b0, 1'b0, 8'd29);
      checkOutput("basic_done",  64'(bus.done),  64'd1);
      checkOutput("basic_busy",  64'(bus.busy),  64'd0);
      checkOutput("basic_count", 64'(bus.count), 64'd6);
      checkOutput("basic_nums",  64'(bus.nums),  NUMS_A);
      applyStimulus(1'b0, 1'b0, 8'd40);
      checkOutput("basic_done_drop", 64'(bus.done), 64'd0);
      checkOutput("basic_hold",      64'(bus.nums), NUMS_A);

      // Rejections
      applyStimulus(1'b0, 1'b1, 8'd0);
      pulses = 0;
      foreach (rej[i]) begin
         applyStimulus(1'b0, 1'b0, 8'(rej[i]));
         if (bus.done) pulses++;
      end
      checkOutput("rej_count", 64'(bus.count), 64'd6);
      checkOutput("rej_nums",  64'(bus.nums),  NUMS_A);
      applyStimulus(1'b0, 1'b0, 8'd9);
      if (bus.done) pulses++;
      checkOutput("rej_done_pulses", 64'(pulses), 64'd1);

      // Range boundaries
      applyStimulus(1'b0, 1'b1, 8'd0);
      foreach (bnd[i]) applyStimulus(1'b0, 1'b0, 8'(bnd[i]));
      checkOutput("bnd_done", 64'(bus.done), 64'd1);
      checkOutput("bnd_nums", 64'(bus.nums), NUMS_B);

      // Timeout
      applyStimulus(1'b0, 1'b1, 8'd0);
      applyStimulus(1'b0, 1'b0, 8'd33);
      for (int i = 0; i < 63; i++) applyStimulus(1'b0, 1'b0, 8'd33);
      checkOutput("to_busy_before", 64'(bus.busy), 64'd1);
      checkOutput("to_err_before",  64'(bus.err),  64'd0);
      applyStimulus(1'b0, 1'b0, 8'd33);
      checkOutput("to_busy",  64'(bus.busy),  64'd0);
      checkOutput("to_err",   64'(bus.err),   64'd1);
      checkOutput("to_count", 64'(bus.count), 64'd1);
      checkOutput("to_nums",  64'(bus.nums),  64'h21);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'd12);
      checkOutput("to_err_hold", 64'(bus.err), 64'd1);
      applyStimulus(1'b0, 1'b1, 8'd40);
      checkOutput("to_err_clear",   64'(bus.err),   64'd0);
      checkOutput("to_count_clear", 64'(bus.count), 64'd0);

      // Ignored start, then reset mid-draw
      applyStimulus(1'b0, 1'b0, 8'd33);
      applyStimulus(1'b0, 1'b0, 8'd44);
      applyStimulus(1'b0, 1'b1, 8'd20);
      checkOutput("mid_count", 64'(bus.count), 64'd3);
      checkOutput("mid_busy",  64'(bus.busy),  64'd1);
      applyStimulus(1'b1, 1'b1, 8'd25);
      checkOutput("rst_count", 64'(bus.count), 64'd0);
      checkOutput("rst_nums",  64'(bus.nums),  64'd0);
      checkOutput("rst_busy",  64'(bus.busy),  64'd0);
      applyStimulus(1'b0, 1'b0, 8'd25);
      checkOutput("rst_stays_idle", 64'(bus.busy), 64'd0);

      // Free-running source
      applyStimulus(1'b0, 1'b1, 8'd0);
      seen_at = 0;
      for (int i = 0; i < 40 && seen_at == 0; i++) begin
         applyStimulus(1'b0, 1'b0, 8'(src[i % 16]));
         if (bus.done) seen_at = i + 1;
      end
      checkOutput("free_done_sample", 64'(seen_at), 64'd7);
      checkOutput("free_nums", 64'(bus.nums), NUMS_A);
      applyStimulus(1'b0, 1'b0, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lottery_draw.md
# lottery_draw

Consumer stage for the free-running 8-bit pseudo-random source. On a `start` pulse it samples the random value once per clock and keeps only in-range values not already drawn, until NUM_PICKS unique numbers are collected. It then presents them as a held result vector with a one-cycle `done` pulse. A stall timeout aborts the draw when the source stops producing new usable values, because the source has a short period and repeats values.

## Interface
- NUM_PICKS, 6, numbers to draw (1..15)
- WIDTH, 8, width of random input and of each stored number
- MIN_VAL, 1, lowest acceptable value (inclusive)
- MAX_VAL, 49, highest acceptable value (inclusive)
- TIMEOUT, 64, consecutive non-accepting DRAW cycles before abort (2..255)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a draw; honoured only in IDLE or DONE
- rand_in  in  WIDTH  random value from upstream generator, sampled every DRAW cycle
- nums  out  NUM_PICKS*WIDTH  slot i at [i*WIDTH +: WIDTH], in acceptance order
- count  out  4  number of slots filled
- busy  out  1  high in DRAW
- done  out  1  one-cycle pulse when the last slot is filled
- err  out  1  high from timeout until next accepted start or reset

## Operation
- States:
  - IDLE: reset state.
  - DRAW: collecting numbers.
  - DONE: result held.
- Reset: state IDLE; nums, count, busy, done and err all 0; stall counter 0.
- IDLE/DONE + start:
  - Next state DRAW.
  - nums and count cleared to 0, err cleared, stall counter cleared.
- DRAW, each cycle, rand_in is accepted when MIN_VAL <= rand_in <= MAX_VAL and rand_in differs from every slot j < count.
  - Compare against filled slots only. A cleared slot holding 0 is not a match.
  - On accept: slot[count] <= rand_in, count <= count+1, stall counter cleared.
  - On reject: stall counter +1.
- DRAW exits:
  - The accept that makes count == NUM_PICKS moves to DONE and asserts done for that one cycle.
  - Stall counter reaching TIMEOUT-1 with another reject moves to IDLE. err is set; nums and count keep their partial values.
- start during DRAW is ignored.
- In DONE, nums and count hold indefinitely. done is low after its single-cycle pulse.
- Width rules:
  - Range compares are unsigned at WIDTH bits.
  - The count register is 4 bits, so NUM_PICKS must be <= 15.
  - The stall counter is 8 bits and saturates; it does not wrap.

## Timing
- start seen at edge k sets DRAW. rand_in is first sampled at edge k+1.
- Minimum latency: done is high in the cycle after edge k+NUM_PICKS, when every sample is accepted.
- Accept decision is combinational on rand_in and stored slots, registered at the same edge. There is no input pipeline register.
- busy = (state == DRAW), registered.
- err is set in the cycle after the timeout edge.
- A reject and a timeout on the same edge count as a timeout.
- rst overrides start and an accept occurring on the same edge.
- rst asserted mid-DRAW returns every output to its reset value on the next edge.

## Structure
- Package lottery_pkg holds:
  - state encoding (IDLE=0, DRAW=1, DONE=2)
  - default parameter constants
  - width of the count register
- Sub-module lottery_dup_check. It is combinational and takes slots, count and candidate. It outputs `hit` when the candidate equals any filled slot. It is instantiated once.

## Test plan
- Reset then idle: hold rst 2 cycles, then 10 cycles with no start -> nums=0, count=0, busy=0, done=0, err=0.
- Basic draw: start, then rand_in 33,44,20,25,18,29 -> slots 33,44,20,25,18,29; done pulses in the cycle after the 6th sample; busy falls with it.
- Rejections: start, then rand_in 33,33,0,50,44,200,20,25,18,29 -> 33,44,20,25,18,29; count=6 after 10 samples; exactly one done pulse.
- Timeout: start, accept 33, then hold rand_in=33 -> IDLE with err=1 after 64 rejects, count=1, nums slot0=33; a new start clears err and count.
- Reset mid-draw: after 3 accepts (33,44,20) assert rst -> next cycle count=0, nums=0, busy=0; start during DRAW never restarts a draw.
- Free-running source: connect to the generator sequence 33,44,20,25,25,18,29,18,36,1,31,13,22,5,5,5 repeating -> first six unique values 33,44,20,25,18,29 collected, then done.
